// File: rtl/audiosystem_ram_pkg.sv
// Shared types and constants for the audio sample RAM and its playback engine.
package audiosystem_ram_pkg;

    // Playback engine states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } play_state_e;

    // Output buffer between the port B read and the stream interface
    localparam int unsigned FifoDepth = 2;
    localparam int unsigned FifoCntW  = 2;

    // Only a bare RAM output (1) or one extra output register (2) is supported
    function automatic bit mm_rd_lat_ok(input int unsigned lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/audiosystem_skid_fifo.sv
// Two-entry valid/ready buffer with synchronous flush and occupancy count.
module audiosystem_skid_fifo
    import audiosystem_ram_pkg::*;
#(
    parameter int unsigned Width = 33
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                push_i,
    input  logic [Width-1:0]    push_data_i,
    input  logic                pop_i,
    output logic                out_valid_o,
    output logic [Width-1:0]    out_data_o,
    output logic [FifoCntW-1:0] count_o
);

    logic [Width-1:0]    buf_q [FifoDepth];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [FifoCntW-1:0] count_q;
    logic                pop_en;

    // Head presentation and handshake qualification
    always_comb begin
        out_valid_o = (count_q != '0);
        out_data_o  = buf_q[rd_ptr_q];
        count_o     = count_q;
        pop_en      = pop_i & out_valid_o;
    end

    // Storage and pointers; flush beats a simultaneous push/pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(FifoDepth); i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                buf_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_en) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + FifoCntW'(push_i) - FifoCntW'(pop_en);
        end
    end

endmodule

// File: rtl/audiosystem_sample_ram.sv
// Audio sample RAM: Avalon-MM load/readback on port A, streaming playback on port B.
// Build option: define AUDIOSYS_RAM_LOOP_EN to honour play_loop (range repeat).
module audiosystem_sample_ram
    import audiosystem_ram_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned MM_RD_LAT = 1,
    parameter string       INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic                chipselect,
    input  logic                write,
    input  logic                read,
    input  logic [DATA_W-1:0]   writedata,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    input  logic [ADDR_W-1:0]   play_start,
    input  logic [ADDR_W-1:0]   play_end,
    input  logic                play_go,
    input  logic                play_stop,
    input  logic                play_loop,
    output logic                play_busy,
    output logic                play_done,
    output logic [DATA_W-1:0]   src_data,
    output logic                src_valid,
    input  logic                src_ready
);

    localparam int unsigned NumBytes = DATA_W / 8;
    localparam bit          LatOk    = mm_rd_lat_ok(MM_RD_LAT);

    if (!LatOk) begin : g_bad_lat
        $error("audiosystem_sample_ram: MM_RD_LAT must be 1 or 2");
    end

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // ---------------- Port A: Avalon-MM ----------------
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] rdata1_q;
    logic              rvalid1_q;

    assign wr_acc = chipselect & write;
    assign rd_acc = chipselect & read & ~write;   // write wins a read/write collision

    // Byte-lane write
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int unsigned i = 0; i < NumBytes; i++) begin
                if (byteenable[i]) mem[address][8*i +: 8] <= writedata[8*i +: 8];
            end
        end
    end

    // First read stage (RAM q)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata1_q  <= '0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid1_q <= rd_acc;
            if (rd_acc) rdata1_q <= mem[address];
        end
    end

    if (MM_RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] rdata2_q;
        logic              rvalid2_q;

        // Optional extra output register
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rdata2_q  <= '0;
                rvalid2_q <= 1'b0;
            end else begin
                rvalid2_q <= rvalid1_q;
                if (rvalid1_q) rdata2_q <= rdata1_q;
            end
        end
        assign readdata      = rdata2_q;
        assign readdatavalid = rvalid2_q;
    end else begin : g_lat1
        assign readdata      = rdata1_q;
        assign readdatavalid = rvalid1_q;
    end

    // ---------------- Port B: playback engine ----------------
    play_state_e         state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, start_q, end_q;
    logic                loop_q, loop_in;
    logic                inflight_q, inflight_last_q;
    logic [DATA_W-1:0]   q_b;
    logic                fetch, fetch_last, go, at_end, hs, head_last;
    logic [ADDR_W-1:0]   fetch_addr;
    logic [FifoCntW-1:0] fifo_count, eff_count;
    logic [FifoCntW:0]   occ;
    logic [DATA_W:0]     fifo_out;

`ifdef AUDIOSYS_RAM_LOOP_EN
    assign loop_in = play_loop;

    // Loop mode captured at start of playback
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   loop_q <= 1'b0;
        else if (go) loop_q <= play_loop;
    end
`else
    logic unused_play_loop;
    assign unused_play_loop = play_loop;
    assign loop_in          = 1'b0;
    assign loop_q           = 1'b0;
`endif

    // Occupancy excludes the word handshaking this cycle so a full-rate stream never bubbles
    always_comb begin
        hs        = src_valid & src_ready;
        go        = play_go & ~play_stop & (state_q == StIdle);
        at_end    = (ptr_q == end_q);
        eff_count = fifo_count - FifoCntW'(hs);
        occ       = {1'b0, eff_count} + (FifoCntW + 1)'(inflight_q);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic; stop overrides everything
    always_comb begin
        state_d = state_q;
        if (play_stop) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (go) state_d = fetch_last ? StDrain : StRun;
                StRun:   if (fetch && fetch_last) state_d = StDrain;
                StDrain: if (eff_count == '0 && !inflight_q) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Fetch control; the go cycle itself fetches play_start to save a cycle of latency
    always_comb begin
        fetch      = 1'b0;
        fetch_last = 1'b0;
        fetch_addr = ptr_q;
        case (state_q)
            StIdle: begin
                fetch_addr = play_start;
                fetch      = go;
                fetch_last = !loop_in && (play_start == play_end);
            end
            StRun: begin
                fetch      = !play_stop && (occ < (FifoCntW + 1)'(FifoDepth));
                fetch_last = !loop_q && at_end;
            end
            default: ;
        endcase
    end

    // Pointer, range latch and in-flight tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q           <= '0;
            start_q         <= '0;
            end_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= fetch;
            inflight_last_q <= fetch & fetch_last;
            if (go) begin
                start_q <= play_start;
                end_q   <= play_end;
                ptr_q   <= (loop_in && play_start == play_end) ? play_start : play_start + 1'b1;
            end else if (state_q == StRun && fetch) begin
                ptr_q   <= (loop_q && at_end) ? start_q : ptr_q + 1'b1;
            end
        end
    end

    // Port B read; same-cycle port A write to this address yields the old word
    always_ff @(posedge clk) begin
        if (fetch) q_b <= mem[fetch_addr];
    end

    audiosystem_skid_fifo #(
        .Width (DATA_W + 1)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (reset),
        .flush_i     (play_stop),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, q_b}),
        .pop_i       (src_ready),
        .out_valid_o (src_valid),
        .out_data_o  (fifo_out),
        .count_o     (fifo_count)
    );

    // Stream and status outputs
    always_comb begin
        src_data  = fifo_out[DATA_W-1:0];
        head_last = fifo_out[DATA_W];
        play_busy = (state_q != StIdle);
        play_done = hs & head_last & ~play_stop;
    end

endmodule
